uart_tx: RTL and testbench

Serial UART transmitter that sits directly downstream of the message printer in the bit-reversal design. It accepts one byte per handshake on `data`/`new_data`, reports occupancy on `busy` (which feeds the printer's `tx_busy`), and shifts the byte out on `tx` as an 8-bit, LSB-first asynchronous frame. It supports a programmable bit period, optional parity and a flow-control `block` input.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8-bit LSB-first UART transmitter with programmable bit period, optional parity
// and a block input that holds off new frames. Outputs are registered.
module uart_tx #(
    parameter int CLK_PER_BIT = 50,
    parameter int PARITY      = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       block,
    input  logic [7:0] data,
    input  logic       new_data,
    output logic       busy,
    output logic       tx,
    output logic [2:0] o_state
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(CLK_PER_BIT - 1);
    localparam logic ODD_PAR = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t          r_state;
    logic [2:0]      r_bit_cnt;
    logic [CW-1:0]   r_cyc_cnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic            r_tx;
    logic            r_busy;
    logic            w_bit_end;

    assign w_bit_end = (r_cyc_cnt == LAST_CYC);
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign o_state   = r_state;

    // tx is loaded with the next bit's value on the edge that ends the current
    // bit, so the line changes exactly on bit boundaries with no extra delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_cyc_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_busy    <= block;
                    r_cyc_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (new_data && !block) begin
                        r_shift <= data;
                        r_par   <= 1'b0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= '0;
                        r_par     <= r_par ^ r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            if (PARITY != 0) begin
                                r_tx    <= r_par ^ r_shift[0] ^ ODD_PAR;
                                r_state <= S_PAR;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_busy    <= block;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (CPB=4 none/odd/even parity, CPB=50 none),
// line samples decoded and compared against an expected-byte queue.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] blk_v;
    logic [3:0] nd_v;
    logic [7:0] dat_v [4];
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [2:0] st_v [4];

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic rec_tx   [0:599];
    logic rec_busy [0:599];

    always #5 clk = ~clk;

    uart_tx #(.CLK_PER_BIT(4), .PARITY(0)) u_none (
        .clk(clk), .rst_n(rst_n), .block(blk_v[0]), .data(dat_v[0]), .new_data(nd_v[0]),
        .busy(busy_v[0]), .tx(tx_v[0]), .o_state(st_v[0]));
    uart_tx #(.CLK_PER_BIT(4), .PARITY(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .block(blk_v[1]), .data(dat_v[1]), .new_data(nd_v[1]),
        .busy(busy_v[1]), .tx(tx_v[1]), .o_state(st_v[1]));
    uart_tx #(.CLK_PER_BIT(4), .PARITY(2)) u_even (
        .clk(clk), .rst_n(rst_n), .block(blk_v[2]), .data(dat_v[2]), .new_data(nd_v[2]),
        .busy(busy_v[2]), .tx(tx_v[2]), .o_state(st_v[2]));
    uart_tx #(.CLK_PER_BIT(50), .PARITY(0)) u_slow (
        .clk(clk), .rst_n(rst_n), .block(blk_v[3]), .data(dat_v[3]), .new_data(nd_v[3]),
        .busy(busy_v[3]), .tx(tx_v[3]), .o_state(st_v[3]));

    // Expected line level at frame position pos (0 = start, 1..8 data, 9 parity/stop).
    function automatic logic frame_bit(input logic [7:0] b, input int par, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (pos == 9 && par != 0) return (^b) ^ (par == 1);
        return 1'b1;
    endfunction

    function automatic logic [7:0] decode(input int cpb, input int base);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = rec_tx[base + (1 + i) * cpb + cpb / 2];
        return d;
    endfunction

    // Called right after a falling edge; the request is seen on the next rising edge.
    task automatic start_send(input int idx, input logic [7:0] b, input bit push);
        nd_v[idx]  = 1'b1;
        dat_v[idx] = b;
        if (push) exp_q.push_back(b);
    endtask

    task automatic record(input int idx, input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            nd_v = '0;
            rec_tx[t]   = tx_v[idx];
            rec_busy[t] = busy_v[idx];
        end
    endtask

    task automatic test_reset;
        logic st_ok;
        rst_n = 1'b0;
        blk_v = '0;
        nd_v  = '0;
        for (int i = 0; i < 4; i++) dat_v[i] = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_v !== 4'hF) begin
            n_errors++; $display("FAIL reset_tx: got %b expected 1111", tx_v);
        end
        n_checks++;
        if (busy_v !== 4'h0) begin
            n_errors++; $display("FAIL reset_busy: got %b expected 0000", busy_v);
        end
        st_ok = 1'b1;
        for (int i = 0; i < 4; i++) if (st_v[i] !== 3'd0) st_ok = 1'b0;
        n_checks++;
        if (!st_ok) begin
            n_errors++; $display("FAIL reset_state: got %0d expected 0", st_v[0]);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx_v !== 4'hF || busy_v !== 4'h0) begin
            n_errors++; $display("FAIL post_reset_idle: got tx=%b busy=%b expected 1111/0000", tx_v, busy_v);
        end
    endtask

    task automatic test_reset_midframe;
        int bad;
        start_send(0, 8'hA5, 1'b0);
        record(0, 18);
        n_checks++;
        if (rec_tx[0] !== 1'b0 || rec_tx[16] !== 1'b0 || rec_tx[17] !== 1'b0) begin
            n_errors++; $display("FAIL midframe_pre: got start=%b bit3=%b expected 0/0", rec_tx[0], rec_tx[17]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            n_errors++; $display("FAIL midframe_reset_async: got tx=%b busy=%b expected 1/0", tx_v[0], busy_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        record(0, 50);
        bad = 0;
        for (int t = 0; t < 50; t++) if (rec_tx[t] !== 1'b1 || rec_busy[t] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL after_reset_quiet: got %0d non-idle cycles expected 0", bad);
        end
    endtask

    task automatic test_basic_frame;
        logic [7:0] got;
        logic [7:0] want;
        int cnt;
        start_send(0, 8'h41, 1'b1);
        record(0, 41);
        for (int pos = 0; pos < 10; pos++) begin
            logic ok;
            logic bad_v;
            ok = 1'b1;
            bad_v = 1'b0;
            for (int c = 0; c < 4; c++)
                if (rec_tx[pos * 4 + c] !== frame_bit(8'h41, 0, pos)) begin
                    ok = 1'b0; bad_v = rec_tx[pos * 4 + c];
                end
            n_checks++;
            if (!ok) begin
                n_errors++; $display("FAIL basic_bit%0d: got %b expected %b", pos, bad_v, frame_bit(8'h41, 0, pos));
            end
        end
        cnt = 0;
        for (int t = 0; t <= 40; t++) if (rec_busy[t] === 1'b1) cnt++;
        n_checks++;
        if (cnt != 40 || rec_busy[40] !== 1'b0 || rec_tx[40] !== 1'b1) begin
            n_errors++; $display("FAIL basic_busy_len: got %0d cycles (end busy=%b tx=%b) expected 40 (0/1)", cnt, rec_busy[40], rec_tx[40]);
        end
        got = decode(4, 0);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL basic_decode: got %h expected %h", got, want);
        end
    endtask

    task automatic test_parity;
        int         idx_t [3];
        logic [7:0] byte_t [3];
        logic       par_t [3];
        idx_t  = '{2, 1, 1};
        byte_t = '{8'h41, 8'h41, 8'hFF};
        par_t  = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            logic [7:0] got;
            logic [7:0] want;
            int cnt;
            logic pok;
            start_send(idx_t[k], byte_t[k], 1'b1);
            record(idx_t[k], 45);
            pok = 1'b1;
            for (int c = 36; c < 40; c++) if (rec_tx[c] !== par_t[k]) pok = 1'b0;
            n_checks++;
            if (!pok) begin
                n_errors++; $display("FAIL parity_bit%0d: got %b expected %b", k, rec_tx[37], par_t[k]);
            end
            cnt = 0;
            for (int t = 0; t <= 44; t++) if (rec_busy[t] === 1'b1) cnt++;
            n_checks++;
            if (cnt != 44 || rec_busy[44] !== 1'b0 || rec_tx[40] !== 1'b1 || rec_tx[43] !== 1'b1) begin
                n_errors++; $display("FAIL parity_len%0d: got %0d cycles expected 44", k, cnt);
            end
            got = decode(4, 0);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (got !== want) begin
                n_errors++; $display("FAIL parity_decode%0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit sent2;
        int second_at;
        int bad;
        sent2 = 1'b0;
        second_at = -1;
        start_send(0, 8'h55, 1'b1);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            nd_v = '0;
            rec_tx[t]   = tx_v[0];
            rec_busy[t] = busy_v[0];
            if (t == 10) begin
                nd_v[0] = 1'b1; dat_v[0] = 8'h00;
            end else if (!sent2 && busy_v[0] === 1'b0) begin
                start_send(0, 8'hAA, 1'b1);
                sent2 = 1'b1;
                second_at = t + 1;
            end
        end
        n_checks++;
        if (second_at != 41 || rec_tx[40] !== 1'b1 || rec_tx[41] !== 1'b0) begin
            n_errors++; $display("FAIL b2b_gap: got second start at %0d expected 41", second_at);
        end
        for (int f = 0; f < 2; f++) begin
            logic [7:0] got;
            logic [7:0] want;
            got = decode(4, f * 41);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (got !== want) begin
                n_errors++; $display("FAIL b2b_decode%0d: got %h expected %h", f, got, want);
            end
        end
        bad = 0;
        for (int t = 81; t < 100; t++) if (rec_tx[t] !== 1'b1 || rec_busy[t] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL b2b_no_third: got %0d non-idle cycles expected 0", bad);
        end
    endtask

    task automatic test_flow_control;
        int bad;
        logic [7:0] got;
        logic [7:0] want;
        blk_v[0] = 1'b1;
        record(0, 2);
        n_checks++;
        if (rec_busy[1] !== 1'b1) begin
            n_errors++; $display("FAIL block_busy: got %b expected 1", rec_busy[1]);
        end
        start_send(0, 8'h33, 1'b0);
        record(0, 10);
        bad = 0;
        for (int t = 0; t < 10; t++) if (rec_tx[t] !== 1'b1 || rec_busy[t] !== 1'b1) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL block_drop: got %0d bad cycles expected 0", bad);
        end
        blk_v[0] = 1'b0;
        record(0, 1);
        n_checks++;
        if (rec_busy[0] !== 1'b0) begin
            n_errors++; $display("FAIL unblock_busy: got %b expected 0", rec_busy[0]);
        end
        record(0, 20);
        bad = 0;
        for (int t = 0; t < 20; t++) if (rec_tx[t] !== 1'b1 || rec_busy[t] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL block_not_queued: got %0d bad cycles expected 0", bad);
        end
        start_send(0, 8'h0F, 1'b1);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            nd_v = '0;
            rec_tx[t]   = tx_v[0];
            rec_busy[t] = busy_v[0];
            if (t == 5) blk_v[0] = 1'b1;
        end
        bad = 0;
        for (int t = 0; t < 40; t++) if (rec_tx[t] !== frame_bit(8'h0F, 0, t / 4)) bad++;
        for (int t = 40; t < 50; t++) if (rec_tx[t] !== 1'b1) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL block_mid_frame: got %0d wrong samples expected 0", bad);
        end
        got = decode(4, 0);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL block_decode: got %h expected %h", got, want);
        end
        bad = 0;
        for (int t = 0; t < 50; t++) if (rec_busy[t] !== 1'b1) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL block_busy_hold: got %0d low cycles expected 0", bad);
        end
        blk_v[0] = 1'b0;
        record(0, 1);
        n_checks++;
        if (rec_busy[0] !== 1'b0) begin
            n_errors++; $display("FAIL block_release: got %b expected 0", rec_busy[0]);
        end
    endtask

    task automatic test_bit_period;
        int bad;
        int first_high;
        logic [7:0] got;
        logic [7:0] want;
        start_send(3, 8'h80, 1'b1);
        record(3, 520);
        first_high = -1;
        for (int t = 0; t < 520; t++) if (first_high < 0 && rec_tx[t] === 1'b1) first_high = t;
        n_checks++;
        if (first_high != 400) begin
            n_errors++; $display("FAIL period_low_run: got %0d expected 400", first_high);
        end
        bad = 0;
        for (int t = 0; t < 500; t++) if (rec_tx[t] !== frame_bit(8'h80, 0, t / 50)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL period_bits: got %0d wrong samples expected 0", bad);
        end
        n_checks++;
        if (rec_busy[499] !== 1'b1 || rec_busy[500] !== 1'b0) begin
            n_errors++; $display("FAIL period_busy_end: got %b%b expected 10", rec_busy[499], rec_busy[500]);
        end
        got = decode(50, 0);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL period_decode: got %h expected %h", got, want);
        end
    endtask

    initial begin
        test_reset;
        test_reset_midframe;
        test_basic_frame;
        test_parity;
        test_back_to_back;
        test_flow_control;
        test_bit_period;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
